rfile: RTL and testbench
========================

Name: rfile

Overview:
- 8-entry x 16-bit general-purpose register file for the POCO datapath.
- Sits directly upstream of the ALU: read port A drives ALU operand a, and read port B drives ALU operand b.
- The ALU result y returns through the write port.
- Single clock domain; no internal pipelining beyond the register array itself.

Parameters:
- DEPTH, 8, number of registers (power of two).
- AW, 3, address width, log2(DEPTH).
- DW, 16, data width; matches ALU a/b/y width.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- ra_adr  input  AW  read port A register select.
- rb_adr  input  AW  read port B register select.
- a  output  DW  read port A data (to ALU a).
- b  output  DW  read port B data (to ALU b).
- we  input  1  write enable, sampled on rising clk.
- wadr  input  AW  write register select.
- wdata  input  DW  write data (from ALU y).
- wvalid  output  DEPTH  per-register "written since reset" flags.
- wcount  output  8  saturating count of accepted writes since reset.

Behaviour:
- Reset: one clock (clk); reset is asynchronous and active-low (rst_n).
  - On rst_n low, immediately and without waiting for clk: all registers = 16'h0000, wvalid = 0, wcount = 0.
  - a and b therefore read 16'h0000 during and after reset.
  - Reset asserted mid-write wins; the write is discarded.
- Write:
  - At rising clk with rst_n high and we = 1: reg[wadr] <= wdata, wvalid[wadr] <= 1.
  - wcount <= wcount + 1, saturating at 8'hFF (no wrap).
  - we = 0: no state change.
  - Writes to the same address on consecutive cycles: last write wins.
- Read:
  - Combinational, zero latency: a = reg[ra_adr], b = reg[rb_adr], subject to the optional bypass below.
  - ra_adr == rb_adr is legal; a == b.
  - Read outputs never show X after reset; all entries are initialised.
- Read-during-write (we = 1, wadr equals a read address in the same cycle):
  - Without bypass, the read port shows the old value until the edge and the new value after it.
  - With bypass, see the Optional Feature section.
- Widths:
  - Addresses are AW bits; every address is valid, so there is no out-of-range case.
  - wdata is stored unmodified; no sign or zero extension.
- No handshake. The writer owns we for exactly the cycles it intends to write.
- wvalid and wcount are purely observational. They do not gate reads.

Optional Feature:
- Macro RFILE_BYPASS_EN.
- When defined: write-first forwarding.
  - If we = 1 and wadr == ra_adr, a = wdata combinationally in the same cycle.
  - Likewise b when wadr == rb_adr.
  - This lets a back-to-back ALU result be consumed without waiting one cycle.
- When undefined: read-first.
  - a and b always reflect the array contents.
  - Same-cycle writes become visible only after the rising edge.
- All other behaviour is identical in both builds.

Test Plan:
1. Reset: drive rst_n = 0 mid-cycle with no clk edge -> a = b = 16'h0000, wvalid = 8'h00 and wcount = 0 immediately.
   - Release, then read all 8 addresses -> all 16'h0000.
2. Basic write/read:
   - Write r3 = 16'hFF00 and r5 = 16'hAAAA on two cycles.
   - Set ra_adr = 3, rb_adr = 5 -> a = 16'hFF00, b = 16'hAAAA, wvalid = 8'b0010_1000, wcount = 2.
3. Read-during-write: r2 = 16'h1234, then we = 1, wadr = 2, wdata = 16'hFFFE, ra_adr = 2 before the edge.
   - RFILE_BYPASS_EN undefined -> a = 16'h1234 before the edge, 16'hFFFE after.
   - RFILE_BYPASS_EN defined -> a = 16'hFFFE before the edge.
4. Dual read of the same register: ra_adr = rb_adr = 7 after writing 16'h0008 -> a = b = 16'h0008.
   - Then write 16'hFFF1 to r7 with we held 2 cycles -> r7 = 16'hFFF1, wcount increments by 2.
5. Saturation: 300 consecutive writes to r1 with incrementing data -> wcount = 8'hFF and does not wrap; r1 holds the last data.
6. Reset mid-operation: assert rst_n = 0 coincident with a rising edge while we = 1, wadr = 4, wdata = 16'hBEEF.
   - Result -> r4 = 16'h0000, wvalid[4] = 0, wcount = 0 after release.

Source files
------------

// File: rtl/rfile.sv
// 8 x 16-bit register file feeding ALU operands a/b; ALU result returns via the write port.
// Optional write-first forwarding is enabled by defining RFILE_BYPASS_EN.
module rfile #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned AW    = 3,
    parameter int unsigned DW    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [AW-1:0]    ra_adr,
    input  logic [AW-1:0]    rb_adr,
    output logic [DW-1:0]    a,
    output logic [DW-1:0]    b,
    input  logic             we,
    input  logic [AW-1:0]    wadr,
    input  logic [DW-1:0]    wdata,
    output logic [DEPTH-1:0] wvalid,
    output logic [7:0]       wcount
);

    logic [DW-1:0]    mem_q [DEPTH];
    logic [DEPTH-1:0] wvalid_q;
    logic [7:0]       wcount_q;
    logic [7:0]       wcount_d;

    always_comb begin
        wcount_d = wcount_q;
        if (we && (wcount_q != 8'hFF)) begin
            wcount_d = wcount_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wvalid_q <= '0;
            wcount_q <= '0;
        end else begin
            if (we) begin
                mem_q[wadr]    <= wdata;
                wvalid_q[wadr] <= 1'b1;
            end
            wcount_q <= wcount_d;
        end
    end

`ifdef RFILE_BYPASS_EN
    logic fwd_a;
    logic fwd_b;

    // Forwarding is held off during reset so the operands stay at zero.
    always_comb begin
        fwd_a = rst_n && we && (wadr == ra_adr);
        fwd_b = rst_n && we && (wadr == rb_adr);
        a     = fwd_a ? wdata : mem_q[ra_adr];
        b     = fwd_b ? wdata : mem_q[rb_adr];
    end
`else
    always_comb begin
        a = mem_q[ra_adr];
        b = mem_q[rb_adr];
    end
`endif

    assign wvalid = wvalid_q;
    assign wcount = wcount_q;

endmodule

// File: tb/tb_rfile.sv
// Randomized + directed self-checking bench for rfile against an array-based reference model.
module tb_rfile;

    logic        clk;
    logic        rst_n;
    logic [2:0]  ra_adr;
    logic [2:0]  rb_adr;
    logic [15:0] a;
    logic [15:0] b;
    logic        we;
    logic [2:0]  wadr;
    logic [15:0] wdata;
    logic [7:0]  wvalid;
    logic [7:0]  wcount;

    rfile #(.DEPTH(8), .AW(3), .DW(16)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ra_adr (ra_adr),
        .rb_adr (rb_adr),
        .a      (a),
        .b      (b),
        .we     (we),
        .wadr   (wadr),
        .wdata  (wdata),
        .wvalid (wvalid),
        .wcount (wcount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: register contents, written-flags, accepted-write count.
    logic [15:0] m [8];
    logic [7:0]  mv;
    int          mcnt;

    int tests;
    int fails;

`ifdef RFILE_BYPASS_EN
    localparam bit Bypass = 1'b1;
`else
    localparam bit Bypass = 1'b0;
`endif

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 8; i++) m[i] = 16'h0000;
        mv   = 8'h00;
        mcnt = 0;
    endtask

    function automatic logic [15:0] exp_rd(input logic [2:0] adr);
        if (Bypass && rst_n && we && (wadr == adr)) return wdata;
        return m[adr];
    endfunction

    task automatic check_model(input string tag);
        chk({tag, ".a"}, {16'h0, a}, {16'h0, exp_rd(ra_adr)});
        chk({tag, ".b"}, {16'h0, b}, {16'h0, exp_rd(rb_adr)});
        chk({tag, ".wvalid"}, {24'h0, wvalid}, {24'h0, mv});
        chk({tag, ".wcount"}, {24'h0, wcount}, mcnt);
    endtask

    // One cycle from a negedge: settle, compare, apply the edge to the model, return at negedge.
    task automatic step(input string tag);
        #1;
        check_model(tag);
        @(posedge clk);
        if (rst_n && we) begin
            m[wadr]  = wdata;
            mv[wadr] = 1'b1;
            mcnt     = (mcnt < 255) ? mcnt + 1 : 255;
        end
        @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] adr, input logic [15:0] d);
        we    = 1'b1;
        wadr  = adr;
        wdata = d;
        step("wr");
        we    = 1'b0;
    endtask

    initial begin
        int prev;
        tests  = 0;
        fails  = 0;
        rst_n  = 1'b1;
        we     = 1'b0;
        wadr   = 3'd0;
        wdata  = 16'h0;
        ra_adr = 3'd0;
        rb_adr = 3'd0;
        model_clear();

        // 1. asynchronous reset between clock edges
        #7;
        rst_n = 1'b0;
        #1;
        chk("rst.a", {16'h0, a}, 32'h0);
        chk("rst.b", {16'h0, b}, 32'h0);
        chk("rst.wvalid", {24'h0, wvalid}, 32'h0);
        chk("rst.wcount", {24'h0, wcount}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            ra_adr = 3'(i);
            rb_adr = 3'(7 - i);
            #1;
            chk("rst.read", {16'h0, a}, 32'h0);
            step("rst.scan");
        end

        // 2. basic write/read
        wr(3'd3, 16'hFF00);
        wr(3'd5, 16'hAAAA);
        ra_adr = 3'd3;
        rb_adr = 3'd5;
        #1;
        chk("basic.a", {16'h0, a}, 32'h0000FF00);
        chk("basic.b", {16'h0, b}, 32'h0000AAAA);
        chk("basic.wvalid", {24'h0, wvalid}, 32'h28);
        chk("basic.wcount", {24'h0, wcount}, 32'd2);
        step("basic");

        // 3. read during write
        wr(3'd2, 16'h1234);
        we     = 1'b1;
        wadr   = 3'd2;
        wdata  = 16'hFFFE;
        ra_adr = 3'd2;
        #1;
        chk("rdw.before", {16'h0, a}, Bypass ? 32'h0000FFFE : 32'h00001234);
        step("rdw");
        we = 1'b0;
        #1;
        chk("rdw.after", {16'h0, a}, 32'h0000FFFE);

        // 4. dual read of one register, then a two-cycle write
        wr(3'd7, 16'h0008);
        ra_adr = 3'd7;
        rb_adr = 3'd7;
        #1;
        chk("dual.a", {16'h0, a}, 32'h00000008);
        chk("dual.b", {16'h0, b}, 32'h00000008);
        prev = mcnt;
        we    = 1'b1;
        wadr  = 3'd7;
        wdata = 16'hFFF1;
        step("dual.w0");
        step("dual.w1");
        we = 1'b0;
        #1;
        chk("dual.r7", {16'h0, a}, 32'h0000FFF1);
        chk("dual.cnt", {24'h0, wcount}, prev + 2);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            we     = 1'($urandom_range(0, 1));
            wadr   = 3'($urandom_range(0, 7));
            wdata  = 16'($urandom);
            ra_adr = ($urandom_range(0, 3) == 0) ? wadr : 3'($urandom_range(0, 7));
            rb_adr = 3'($urandom_range(0, 7));
            step("rand");
        end
        we = 1'b0;

        // 5. saturation
        for (int i = 0; i < 300; i++) begin
            we     = 1'b1;
            wadr   = 3'd1;
            wdata  = 16'(i);
            ra_adr = 3'd1;
            step("sat");
        end
        we     = 1'b0;
        ra_adr = 3'd1;
        #1;
        chk("sat.wcount", {24'h0, wcount}, 32'hFF);
        chk("sat.r1", {16'h0, a}, 32'd299);
        wr(3'd0, 16'h5555);
        #1;
        chk("sat.nowrap", {24'h0, wcount}, 32'hFF);

        // 6. reset coincident with a rising edge while writing
        we     = 1'b1;
        wadr   = 3'd4;
        wdata  = 16'hBEEF;
        ra_adr = 3'd4;
        @(posedge clk);
        rst_n = 1'b0;
        model_clear();
        @(negedge clk);
        we    = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("rstw.r4", {16'h0, a}, 32'h0);
        chk("rstw.wvalid4", {31'h0, wvalid[4]}, 32'h0);
        chk("rstw.wcount", {24'h0, wcount}, 32'h0);
        step("rstw");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
